// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the audio-core SDRAM arbitration logic.
//   ADDR_W / DATA_W : SDRAM word address and data widths
//   NUM_CLIENTS     : number of audio cores sharing the SDRAM channel
//   client_e        : client index map (play, record, mix, pitch, load)
//   arb_state_t     : arbiter FSM state encoding
// -----------------------------------------------------------------------------
package sdram_pkg;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 32;
  localparam int NUM_CLIENTS = 5;

  typedef enum logic [2:0] {
    CLI_PLAY   = 3'd0,
    CLI_RECORD = 3'd1,
    CLI_MIX    = 3'd2,
    CLI_PITCH  = 3'd3,
    CLI_LOAD   = 3'd4
  } client_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans req cyclically starting at
// last+1 and reports the first set index.
//   req        : request vector, one bit per client
//   last       : index of the most recently served client
//   winner     : one-hot winner (all zero when nothing is requested)
//   winner_idx : binary index of the winner
//   valid      : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          valid
);

  // One extra bit so last+offset (at most 2N-1) cannot overflow before wrap.
  logic [IW:0] cand;

  always_comb begin
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!valid && req[cand[IW-1:0]]) begin
        valid      = 1'b1;
        winner_idx = cand[IW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign winner[gi] = valid && (winner_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Round-robin owner of the single SDRAM word-access channel shared by the
// audio cores (0 play, 1 record, 2 mix, 3 pitch, 4 load). One client is
// granted at a time; the grant is held until the SDRAM reports completion,
// and the completion pulse / read data are routed back to that client only.
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_req_read/write     : per-client strobes, held until finished
//   i_req_addr/writedata : packed per-client address / write data
//   o_client_finished    : one-cycle completion pulse to the granted client
//   o_client_readdata    : read data captured at completion (broadcast)
//   o_grant, o_busy      : one-hot current owner, transaction in progress
//   o_sdram_*            : latched request towards the SDRAM bus adapter
//   i_sdram_readdata     : read data from the bus adapter
//   i_sdram_finished     : one-cycle completion pulse from the bus adapter
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_CLIENTS = sdram_pkg::NUM_CLIENTS,
  parameter int ADDR_W      = sdram_pkg::ADDR_W,
  parameter int DATA_W      = sdram_pkg::DATA_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        i_req_read,
  input  logic [NUM_CLIENTS-1:0]        i_req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] i_req_writedata,
  output logic [NUM_CLIENTS-1:0]        o_client_finished,
  output logic [DATA_W-1:0]             o_client_readdata,
  output logic [NUM_CLIENTS-1:0]        o_grant,
  output logic                          o_busy,
  output logic                          o_sdram_read,
  output logic                          o_sdram_write,
  output logic [ADDR_W-1:0]             o_sdram_addr,
  output logic [DATA_W-1:0]             o_sdram_writedata,
  input  logic [DATA_W-1:0]             i_sdram_readdata,
  input  logic                          i_sdram_finished
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  arb_state_t state_reg, state_next;

  logic [IW-1:0]          last_reg, last_next;
  logic [NUM_CLIENTS-1:0] grant_reg, grant_next;
  logic [NUM_CLIENTS-1:0] fin_reg, fin_next;
  logic                   read_reg, read_next;
  logic                   write_reg, write_next;
  logic [ADDR_W-1:0]      addr_reg, addr_next;
  logic [DATA_W-1:0]      wdata_reg, wdata_next;
  logic [DATA_W-1:0]      rdata_reg, rdata_next;

  logic [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] pick_onehot;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;

  logic [ADDR_W-1:0]      addr_arr  [NUM_CLIENTS];
  logic [DATA_W-1:0]      wdata_arr [NUM_CLIENTS];

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign addr_arr[gi]  = i_req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = i_req_writedata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign req = i_req_read | i_req_write;

  rr_pick #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) u_rr_pick (
    .req        (req),
    .last       (last_reg),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:    if (pick_valid)       state_next = ST_GRANT;
      ST_GRANT:   if (i_sdram_finished) state_next = ST_RELEASE;
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values; everything visible outside is registered.
  always_comb begin
    last_next  = last_reg;
    grant_next = grant_reg;
    read_next  = read_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    fin_next   = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          last_next  = pick_idx;
          grant_next = pick_onehot;
          addr_next  = addr_arr[pick_idx];
          wdata_next = wdata_arr[pick_idx];
          // Write takes precedence when a client raises both strobes.
          write_next = |(i_req_write & pick_onehot);
          read_next  = |(i_req_read & ~i_req_write & pick_onehot);
        end else begin
          grant_next = '0;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      ST_GRANT: begin
        if (i_sdram_finished) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          rdata_next = i_sdram_readdata;
          fin_next   = grant_reg;
        end
      end
      ST_RELEASE: begin
        // One idle edge lets the client drop or renew before re-arbitration.
        grant_next = '0;
      end
      default: begin
        grant_next = '0;
        read_next  = 1'b0;
        write_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_reg  <= IW'(NUM_CLIENTS - 1);
      grant_reg <= '0;
      fin_reg   <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      last_reg  <= last_next;
      grant_reg <= grant_next;
      fin_reg   <= fin_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  assign o_grant           = grant_reg;
  assign o_client_finished = fin_reg;
  assign o_sdram_read      = read_reg;
  assign o_sdram_write     = write_reg;
  assign o_sdram_addr      = addr_reg;
  assign o_sdram_writedata = wdata_reg;
  assign o_client_readdata = rdata_reg;
  assign o_busy            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed and randomized stimulus for sdram_arbiter. A transaction-level
// model of the clients (pending op, address, data per client) and of the
// round-robin rule predicts each grant and the outputs of every cycle.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int NC = 5;
  localparam int AW = 23;
  localparam int DW = 32;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NC-1:0]     i_req_read = '0;
  logic [NC-1:0]     i_req_write = '0;
  logic [NC*AW-1:0]  i_req_addr = '0;
  logic [NC*DW-1:0]  i_req_writedata = '0;
  logic [NC-1:0]     o_client_finished;
  logic [DW-1:0]     o_client_readdata;
  logic [NC-1:0]     o_grant;
  logic              o_busy;
  logic              o_sdram_read;
  logic              o_sdram_write;
  logic [AW-1:0]     o_sdram_addr;
  logic [DW-1:0]     o_sdram_writedata;
  logic [DW-1:0]     i_sdram_readdata = '0;
  logic              i_sdram_finished = 1'b0;

  sdram_arbiter #(
    .NUM_CLIENTS (NC),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req_read        (i_req_read),
    .i_req_write       (i_req_write),
    .i_req_addr        (i_req_addr),
    .i_req_writedata   (i_req_writedata),
    .o_client_finished (o_client_finished),
    .o_client_readdata (o_client_readdata),
    .o_grant           (o_grant),
    .o_busy            (o_busy),
    .o_sdram_read      (o_sdram_read),
    .o_sdram_write     (o_sdram_write),
    .o_sdram_addr      (o_sdram_addr),
    .o_sdram_writedata (o_sdram_writedata),
    .i_sdram_readdata  (i_sdram_readdata),
    .i_sdram_finished  (i_sdram_finished)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Client-side model
  bit          rd_m   [NC];
  bit          wr_m   [NC];
  logic [AW-1:0] addr_m [NC];
  logic [DW-1:0] wd_m   [NC];
  int          last_m;
  logic [DW-1:0] rdata_m;
  int          order_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NC; k++) begin
      i_req_read[k]                = rd_m[k];
      i_req_write[k]               = wr_m[k];
      i_req_addr[k*AW +: AW]       = addr_m[k];
      i_req_writedata[k*DW +: DW]  = wd_m[k];
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NC; k++) begin
      rd_m[k] = 1'b0;
      wr_m[k] = 1'b0;
      addr_m[k] = '0;
      wd_m[k] = '0;
    end
    apply();
  endtask

  task automatic new_req(input int k);
    int op;
    op = int'($urandom_range(0, 2));
    rd_m[k]   = (op != 1);
    wr_m[k]   = (op != 0);
    addr_m[k] = AW'($urandom);
    wd_m[k]   = $urandom;
  endtask

  // First requesting client scanning cyclically after the last served one.
  function automatic int model_pick();
    for (int i = 1; i <= NC; i++) begin
      int k;
      k = (last_m + i) % NC;
      if (rd_m[k] || wr_m[k]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    last_m  = NC - 1;
    rdata_m = '0;
  endtask

  // One arbitration round starting in IDLE with the current request set.
  task automatic run_txn(input int lat, input logic [DW-1:0] rdat,
                         input bit toggle, input bit spur, input bit renew);
    int w;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    bit exp_wr, exp_rd;
    w = model_pick();
    if (w < 0) begin
      i_sdram_finished = spur;
      i_sdram_readdata = ~rdata_m;
      @(posedge i_clk); #1;
      i_sdram_finished = 1'b0;
      chk("idle_grant", 64'(o_grant), 64'(0));
      chk("idle_fin",   64'(o_client_finished), 64'(0));
      chk("idle_strb",  64'({o_sdram_read, o_sdram_write, o_busy}), 64'(0));
      chk("idle_rdata", 64'(o_client_readdata), 64'(rdata_m));
      $display("txn idle spur=%0d", spur);
      return;
    end
    exp_addr = addr_m[w];
    exp_wd   = wd_m[w];
    exp_wr   = wr_m[w];
    exp_rd   = rd_m[w] & ~wr_m[w];
    @(posedge i_clk); #1;
    last_m = w;
    order_q.push_back(w);
    chk("grant",  64'(o_grant), 64'(1) << w);
    chk("busy",   64'(o_busy), 64'(1));
    chk("strobe", 64'({o_sdram_read, o_sdram_write}), 64'({exp_rd, exp_wr}));
    chk("addr",   64'(o_sdram_addr), 64'(exp_addr));
    chk("wdata",  64'(o_sdram_writedata), 64'(exp_wd));
    for (int c = 1; c < lat; c++) begin
      if (toggle) begin
        addr_m[w] = AW'($urandom);
        wd_m[w]   = $urandom;
        apply();
      end
      @(posedge i_clk); #1;
      chk("hold_strobe", 64'({o_sdram_read, o_sdram_write}), 64'({exp_rd, exp_wr}));
      chk("hold_addr",   64'(o_sdram_addr), 64'(exp_addr));
      chk("hold_wdata",  64'(o_sdram_writedata), 64'(exp_wd));
      chk("hold_fin",    64'(o_client_finished), 64'(0));
      chk("hold_grant",  64'(o_grant), 64'(1) << w);
      chk("hold_rdata",  64'(o_client_readdata), 64'(rdata_m));
    end
    i_sdram_finished = 1'b1;
    i_sdram_readdata = rdat;
    @(posedge i_clk); #1;
    rdata_m = rdat;
    chk("fin",        64'(o_client_finished), 64'(1) << w);
    chk("fin_rdata",  64'(o_client_readdata), 64'(rdat));
    chk("fin_strobe", 64'({o_sdram_read, o_sdram_write}), 64'(0));
    chk("fin_grant",  64'(o_grant), 64'(1) << w);
    chk("fin_busy",   64'(o_busy), 64'(1));
    // Release cycle: spurious completion must be ignored; client drops/renews.
    i_sdram_finished = spur;
    i_sdram_readdata = ~rdat;
    if (renew) new_req(w);
    else begin rd_m[w] = 1'b0; wr_m[w] = 1'b0; end
    apply();
    @(posedge i_clk); #1;
    i_sdram_finished = 1'b0;
    chk("rel_grant", 64'(o_grant), 64'(0));
    chk("rel_fin",   64'(o_client_finished), 64'(0));
    chk("rel_busy",  64'(o_busy), 64'(0));
    chk("rel_rdata", 64'(o_client_readdata), 64'(rdat));
    $display("txn client=%0d rd=%0d wr=%0d addr=%h lat=%0d rdata=%h", w, exp_rd, exp_wr, exp_addr, lat, rdat);
  endtask

  initial begin
    int exp_order [6];
    last_m  = NC - 1;
    rdata_m = '0;
    clear_all();

    // Reset values
    #2;
    chk("rst_outs", 64'({o_grant, o_client_finished, o_busy, o_sdram_read, o_sdram_write}), 64'(0));
    chk("rst_addr", 64'(o_sdram_addr), 64'(0));
    chk("rst_rdata", 64'(o_client_readdata), 64'(0));
    do_reset();

    // Single read by client 0
    rd_m[0] = 1'b1; addr_m[0] = 23'h000100; apply();
    run_txn(5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    run_txn(1, 32'h0, 1'b0, 1'b1, 1'b0);   // spurious finish in IDLE

    // Single write by client 1 with data lines toggling during the grant
    wr_m[1] = 1'b1; addr_m[1] = 23'h7FFFFF; wd_m[1] = 32'h12345678; apply();
    run_txn(4, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);

    // Read and write together on client 2: write wins
    rd_m[2] = 1'b1; wr_m[2] = 1'b1; addr_m[2] = 23'h012345; wd_m[2] = 32'hCAFEF00D; apply();
    run_txn(2, 32'h55AA55AA, 1'b0, 1'b1, 1'b0);
    run_txn(1, 32'h0, 1'b0, 1'b1, 1'b0);

    // Round-robin with all five requesting continuously
    do_reset();
    for (int k = 0; k < NC; k++) new_req(k);
    apply();
    order_q.delete();
    for (int t = 0; t < 6; t++) run_txn(3, $urandom, 1'b0, 1'b0, 1'b1);
    exp_order = '{0, 1, 2, 3, 4, 0};
    for (int t = 0; t < 6; t++) chk("rr_order", 64'(order_q[t]), 64'(exp_order[t]));
    clear_all();

    // Reset while client 3 is granted
    rd_m[3] = 1'b1; addr_m[3] = 23'h003333; apply();
    @(posedge i_clk); #1;
    chk("pre_rst_grant", 64'(o_grant), 64'(5'b01000));
    rd_m[0] = 1'b1; addr_m[0] = 23'h000010; apply();
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst_outs", 64'({o_grant, o_client_finished, o_busy, o_sdram_read, o_sdram_write}), 64'(0));
    chk("async_rst_addr", 64'(o_sdram_addr), 64'(0));
    chk("async_rst_rdata", 64'(o_client_readdata), 64'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    last_m  = NC - 1;
    rdata_m = '0;
    order_q.delete();
    run_txn(2, 32'h0BADCAFE, 1'b0, 1'b0, 1'b0);
    chk("post_rst_winner", 64'(order_q[0]), 64'(0));

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < NC; k++)
        if (!rd_m[k] && !wr_m[k] && ($urandom_range(0, 2) == 0)) new_req(k);
      apply();
      run_txn(int'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
